// File: rtl/fwd_capture_unit.sv
// rtl/fwd_capture_unit.sv - EX operand forwarding with load-use stall and hold-time capture
// Optional feature macro: FWD_PERF_EN (stall/forward performance counters)
module fwd_capture_unit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int NSTAGE = 2,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ex_hold,
  input  logic [NSRC-1:0]          src_valid,
  input  logic [NSRC*REG_W-1:0]    src_reg,
  input  logic [NSTAGE-1:0]        prod_wen,
  input  logic [NSTAGE*REG_W-1:0]  prod_dst,
  input  logic [NSTAGE-1:0]        prod_rdy,
  input  logic [NSTAGE*DATA_W-1:0] prod_data,
  input  logic                     perf_clr,
  output logic [NSRC-1:0]          fwd_en,
  output logic [NSRC*DATA_W-1:0]   fwd_data,
  output logic                     stall_o,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         fwd_count
);

  logic [NSRC-1:0]        cap_v_q, cap_v_d;
  logic [NSRC*DATA_W-1:0] cap_d_q, cap_d_d;
  logic [NSRC-1:0]        not_rdy;
  logic                   hit;
  logic                   hit_rdy;
  logic [DATA_W-1:0]      hit_data;

  // Per operand: find youngest matching producer, then pick capture, producer data or stall
  always_comb begin
    fwd_en   = '0;
    fwd_data = '0;
    not_rdy  = '0;
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      hit      = 1'b0;
      hit_rdy  = 1'b0;
      hit_data = '0;
      // Scan oldest to youngest so the youngest match is the last one written
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (src_valid[i] && prod_wen[k] &&
            (prod_dst[k*REG_W +: REG_W] == src_reg[i*REG_W +: REG_W]) &&
            (src_reg[i*REG_W +: REG_W] != '0)) begin
          hit      = 1'b1;
          hit_rdy  = prod_rdy[k];
          hit_data = prod_data[k*DATA_W +: DATA_W];
        end
      end
      if (cap_v_q[i]) begin
        fwd_en[i]                     = 1'b1;
        fwd_data[i*DATA_W +: DATA_W] = cap_d_q[i*DATA_W +: DATA_W];
      end else if (hit && hit_rdy) begin
        fwd_en[i]                     = 1'b1;
        fwd_data[i*DATA_W +: DATA_W] = hit_data;
      end else if (hit) begin
        not_rdy[i] = 1'b1;
      end
    end
    stall_o = |not_rdy;
  end

  // Capture forwarded values on the first held cycle; drop them once EX advances
  always_comb begin
    cap_v_d = cap_v_q;
    cap_d_d = cap_d_q;
    for (int i = 0; i < NSRC; i++) begin
      if (!ex_hold) begin
        cap_v_d[i] = 1'b0;
      end else if (!cap_v_q[i] && fwd_en[i]) begin
        cap_v_d[i]                   = 1'b1;
        cap_d_d[i*DATA_W +: DATA_W] = fwd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Capture state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap_v_q <= '0;
      cap_d_q <= '0;
    end else begin
      cap_v_q <= cap_v_d;
      cap_d_q <= cap_d_d;
    end
  end

`ifdef FWD_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] fwd_count_q, fwd_count_d;
  logic [CNT_W-1:0] cnt_one;

  assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating counters; clear wins over a coincident increment
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    fwd_count_d    = fwd_count_q;
    if (perf_clr) begin
      stall_cycles_d = '0;
      fwd_count_d    = '0;
    end else begin
      if (stall_o && !(&stall_cycles_q)) begin
        stall_cycles_d = stall_cycles_q + cnt_one;
      end
      if (!ex_hold && (|fwd_en) && !(&fwd_count_q)) begin
        fwd_count_d = fwd_count_q + cnt_one;
      end
    end
  end

  // Performance counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles_q <= '0;
      fwd_count_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_count_q    <= fwd_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_count    = fwd_count_q;
`else
  logic unused_perf_clr;

  assign unused_perf_clr = perf_clr;
  assign stall_cycles    = '0;
  assign fwd_count       = '0;
`endif

endmodule

// File: tb/tb_fwd_capture_unit.sv
// tb/tb_fwd_capture_unit.sv - directed vector bench for fwd_capture_unit
module tb_fwd_capture_unit;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int NSTAGE = 2;
  localparam int NSRC   = 2;
  localparam int CNT_W  = 4;

  logic                     CLK = 1'b0;
  logic                     RST;
  logic                     ex_hold;
  logic [NSRC-1:0]          src_valid;
  logic [NSRC*REG_W-1:0]    src_reg;
  logic [NSTAGE-1:0]        prod_wen;
  logic [NSTAGE*REG_W-1:0]  prod_dst;
  logic [NSTAGE-1:0]        prod_rdy;
  logic [NSTAGE*DATA_W-1:0] prod_data;
  logic                     perf_clr;
  logic [NSRC-1:0]          fwd_en;
  logic [NSRC*DATA_W-1:0]   fwd_data;
  logic                     stall_o;
  logic [CNT_W-1:0]         stall_cycles;
  logic [CNT_W-1:0]         fwd_count;

  int checks = 0;
  int errors = 0;

  fwd_capture_unit #(
    .DATA_W(DATA_W), .REG_W(REG_W), .NSTAGE(NSTAGE), .NSRC(NSRC), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .ex_hold(ex_hold),
    .src_valid(src_valid), .src_reg(src_reg),
    .prod_wen(prod_wen), .prod_dst(prod_dst), .prod_rdy(prod_rdy), .prod_data(prod_data),
    .perf_clr(perf_clr),
    .fwd_en(fwd_en), .fwd_data(fwd_data), .stall_o(stall_o),
    .stall_cycles(stall_cycles), .fwd_count(fwd_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [1:0]  sv;
    logic [9:0]  sr;
    logic [1:0]  pw;
    logic [9:0]  pd;
    logic [1:0]  pr;
    logic [63:0] pdat;
    logic [1:0]  efe;
    logic [63:0] efd;
    logic        est;
  } vec_t;

  vec_t vecs[10];

`ifdef FWD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ex_hold   = 1'b0;
    src_valid = '0;
    src_reg   = '0;
    prod_wen  = '0;
    prod_dst  = '0;
    prod_rdy  = '0;
    prod_data = '0;
    perf_clr  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{"youngest_wins",   2'b01, {5'd0, 5'd5},  2'b11, {5'd5, 5'd5},  2'b11,
                {32'h22, 32'h11}, 2'b01, {32'h0, 32'h11}, 1'b0};
    vecs[1] = '{"reg_zero_ready",  2'b10, {5'd0, 5'd0},  2'b01, {5'd0, 5'd0},  2'b01,
                {32'h0, 32'hFF},  2'b00, 64'h0, 1'b0};
    vecs[2] = '{"reg_zero_notrdy", 2'b10, {5'd0, 5'd0},  2'b01, {5'd0, 5'd0},  2'b00,
                {32'h0, 32'hFF},  2'b00, 64'h0, 1'b0};
    vecs[3] = '{"older_only",      2'b01, {5'd0, 5'd7},  2'b11, {5'd7, 5'd3},  2'b10,
                {32'h33, 32'h44}, 2'b01, {32'h0, 32'h33}, 1'b0};
    vecs[4] = '{"young_notrdy",    2'b01, {5'd0, 5'd6},  2'b11, {5'd6, 5'd6},  2'b10,
                {32'h66, 32'h77}, 2'b00, 64'h0, 1'b1};
    vecs[5] = '{"src_invalid",     2'b00, {5'd0, 5'd6},  2'b01, {5'd0, 5'd6},  2'b01,
                {32'h0, 32'h77},  2'b00, 64'h0, 1'b0};
    vecs[6] = '{"duplicate",       2'b11, {5'd4, 5'd4},  2'b01, {5'd0, 5'd4},  2'b01,
                {32'h0, 32'h55},  2'b11, {32'h55, 32'h55}, 1'b0};
    vecs[7] = '{"wen_low",         2'b01, {5'd0, 5'd6},  2'b00, {5'd0, 5'd6},  2'b01,
                {32'h0, 32'h77},  2'b00, 64'h0, 1'b0};
    vecs[8] = '{"two_stages",      2'b11, {5'd9, 5'd2},  2'b11, {5'd9, 5'd2},  2'b11,
                {32'hAA, 32'hBB}, 2'b11, {32'hAA, 32'hBB}, 1'b0};
    vecs[9] = '{"op1_stall",       2'b10, {5'd12, 5'd0}, 2'b10, {5'd12, 5'd0}, 2'b01,
                {32'hC, 32'hD},   2'b00, 64'h0, 1'b1};

    idle_inputs();
    RST = 1'b1;
    #3;
    check("reset_fwd_en", 64'(fwd_en), 64'h0);
    check("reset_stall", 64'(stall_o), 64'h0);
    check("reset_stall_cycles", 64'(stall_cycles), 64'h0);
    check("reset_fwd_count", 64'(fwd_count), 64'h0);
    tick();
    RST = 1'b0;
    tick();

    // Combinational selection vectors with EX advancing (no capture)
    for (int v = 0; v < 10; v++) begin
      src_valid = vecs[v].sv;
      src_reg   = vecs[v].sr;
      prod_wen  = vecs[v].pw;
      prod_dst  = vecs[v].pd;
      prod_rdy  = vecs[v].pr;
      prod_data = vecs[v].pdat;
      #1;
      check({vecs[v].name, "_en"},    64'(fwd_en),   64'(vecs[v].efe));
      check({vecs[v].name, "_data"},  64'(fwd_data), vecs[v].efd);
      check({vecs[v].name, "_stall"}, 64'(stall_o),  64'(vecs[v].est));
    end

    // Load-use: three stall cycles, then data arrives
    do_reset();
    ex_hold   = 1'b1;
    src_valid = 2'b01;
    src_reg   = {5'd0, 5'd8};
    prod_wen  = 2'b01;
    prod_dst  = {5'd0, 5'd8};
    prod_rdy  = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lu_stall", 64'(stall_o), 64'h1);
      check("lu_no_fwd", 64'(fwd_en), 64'h0);
      tick();
    end
    ex_hold   = 1'b0;
    prod_rdy  = 2'b01;
    prod_data = {32'h0, 32'hABCD};
    #1;
    check("lu_stall_clear", 64'(stall_o), 64'h0);
    check("lu_fwd_en", 64'(fwd_en), 64'h1);
    check("lu_fwd_data", 64'(fwd_data[31:0]), 64'hABCD);
    check("lu_stall_cycles", 64'(stall_cycles), PERF ? 64'd3 : 64'd0);

    // Capture across hold on operand 1
    do_reset();
    ex_hold   = 1'b1;
    src_valid = 2'b10;
    src_reg   = {5'd9, 5'd0};
    prod_wen  = 2'b10;
    prod_dst  = {5'd9, 5'd0};
    prod_rdy  = 2'b10;
    prod_data = {32'h1234, 32'h0};
    #1;
    check("cap_first_en", 64'(fwd_en), 64'h2);
    tick();
    prod_wen  = 2'b00;
    prod_rdy  = 2'b00;
    prod_data = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("cap_hold_en", 64'(fwd_en), 64'h2);
      check("cap_hold_data", 64'(fwd_data[63:32]), 64'h1234);
      tick();
    end
    ex_hold = 1'b0;
    #1;
    check("cap_release_data", 64'(fwd_data[63:32]), 64'h1234);
    check("cap_release_en", 64'(fwd_en), 64'h2);
    tick();
    check("cap_cleared_en", 64'(fwd_en), 64'h0);
    check("cap_cleared_data", 64'(fwd_data), 64'h0);
    check("cap_fwd_count", 64'(fwd_count), PERF ? 64'd1 : 64'd0);

    // Asynchronous reset in the middle of a hold
    ex_hold   = 1'b1;
    src_valid = 2'b01;
    src_reg   = {5'd0, 5'd3};
    prod_wen  = 2'b01;
    prod_dst  = {5'd0, 5'd3};
    prod_rdy  = 2'b01;
    prod_data = {32'h0, 32'h77};
    tick();
    prod_wen  = 2'b00;
    prod_rdy  = 2'b00;
    #1;
    check("ar_captured", 64'(fwd_en), 64'h1);
    #1;
    RST = 1'b1;
    #1;
    check("ar_fwd_en", 64'(fwd_en), 64'h0);
    check("ar_stall_cycles", 64'(stall_cycles), 64'h0);
    check("ar_fwd_count", 64'(fwd_count), 64'h0);
    tick();
    RST = 1'b0;

    // Counter saturation and clear
    do_reset();
    ex_hold   = 1'b1;
    src_valid = 2'b01;
    src_reg   = {5'd0, 5'd8};
    prod_wen  = 2'b01;
    prod_dst  = {5'd0, 5'd8};
    prod_rdy  = 2'b00;
    for (int c = 0; c < 20; c++) tick();
    check("sat_stall", 64'(stall_o), 64'h1);
    check("sat_stall_cycles", 64'(stall_cycles), PERF ? 64'd15 : 64'd0);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("clr_stall_cycles", 64'(stall_cycles), 64'h0);
    tick();
    check("after_clr_count", 64'(stall_cycles), PERF ? 64'd1 : 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_capture_unit.md
# fwd_capture_unit

Parametrised operand forwarding unit for the pipelined datapath, sitting between the EX-stage operand muxes and the NSTAGE younger-than-register-file producer stages (MEM, WB, …). For NSRC operands it selects the youngest matching in-flight producer. It raises a load-use stall when that producer's data is not yet available. While EX is frozen, it captures forwarded values into per-operand holding registers, so data retiring out of the pipeline during a stall is not lost.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_W, 5, register index width (register 0 hardwired zero)
- NSTAGE, 2, producer stages; index 0 = youngest (MEM), NSTAGE-1 = oldest
- NSRC, 2, EX operands checked (0 = rs, 1 = rt)
- CNT_W, 16, perf counter width

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- ex_hold  in  1  EX stage frozen this cycle (any stall source, including our own stall_o)
- src_valid  in  NSRC  operand i is read by the EX instruction
- src_reg  in  NSRC*REG_W  operand register indices, operand i at [i*REG_W +: REG_W]
- prod_wen  in  NSTAGE  stage k will write a register
- prod_dst  in  NSTAGE*REG_W  destination of stage k
- prod_rdy  in  NSTAGE  stage k result valid this cycle (0 for load awaiting dcache)
- prod_data  in  NSTAGE*DATA_W  result of stage k
- perf_clr  in  1  synchronous clear of perf counters
- fwd_en  out  NSRC  operand i must take fwd_data, not register file
- fwd_data  out  NSRC*DATA_W  forwarded operand values
- stall_o  out  1  load-use stall request
- stall_cycles  out  CNT_W  perf: cycles with stall_o=1
- fwd_count  out  CNT_W  perf: EX-advancing cycles with ≥1 fwd_en

## Operation
- Match for operand i at stage k: src_valid[i] & prod_wen[k] & prod_dst[k]==src_reg[i] & src_reg[i]!=0.
- Selection: lowest matching k wins (youngest); older matches ignored.
- Per operand state: cap_v[i] (1 bit), cap_d[i] (DATA_W).
- Output, cap_v[i]=1: fwd_en[i]=1, fwd_data[i]=cap_d[i]; producer matches ignored.
- Output, cap_v[i]=0, winning k with prod_rdy[k]=1: fwd_en[i]=1, fwd_data[i]=prod_data[k].
- Output, cap_v[i]=0, winning k with prod_rdy[k]=0: fwd_en[i]=0, fwd_data[i]=0, operand contributes to stall_o.
- Output, no match: fwd_en[i]=0, fwd_data[i]=0.
- stall_o = OR over operands of the not-ready condition.
- Capture, each edge: if !ex_hold, cap_v[i]←0. Else if cap_v[i]=0 and fwd_en[i]=1, cap_v[i]←1 and cap_d[i]←fwd_data[i]. Otherwise hold.
- A captured value is never overwritten while ex_hold stays 1. Stages ahead of a frozen EX receive only bubbles, so no newer producer can appear.
- Register 0 is never forwarded, never stalls, never captured.
- Duplicate operands (src_reg[0]==src_reg[1]) are resolved independently and give identical results.

## Timing
- Select, fwd_data, and stall_o are combinational from inputs and capture state: zero latency.
- Capture is visible the cycle after the first held cycle in which data was forwarded.
- Capture clears one edge after ex_hold falls. The EX-advancing cycle still uses captured data.
- Reset (asynchronous, RST=1): cap_v=0, cap_d=0, stall_cycles=0, fwd_count=0. Outputs then equal pure combinational select.
- Reset mid-stall discards all captured values immediately.
- Stall then data arrival: cycle n stall_o=1; cycle n+m prod_rdy=1 gives stall_o=0 and fwd_en=1 in the same cycle.
- Perf counters saturate at 2^CNT_W-1. If perf_clr and an increment coincide, the counter becomes 0.

## Configuration
- FWD_PERF_EN defined: stall_cycles and fwd_count implemented as above.
- FWD_PERF_EN undefined: no counter flops. stall_cycles and fwd_count are tied to 0 and perf_clr is ignored. Ports remain so integration is unchanged.

## Test plan
- Youngest wins: src_reg[0]=5; stage0 dst=5 data=0x11, stage1 dst=5 data=0x22, both ready → fwd_en[0]=1, fwd_data[0]=0x11, stall_o=0.
- Register zero: src_reg[1]=0; stage0 wen dst=0 data=0xFF → fwd_en[1]=0, stall_o=0.
- Load-use: src_reg[0]=8; stage0 dst=8 prod_rdy=0 for 3 cycles, then 1 with 0xABCD → stall_o=1 for 3 cycles, then fwd_data[0]=0xABCD. With FWD_PERF_EN, stall_cycles=3.
- Capture across hold: ex_hold=1; stage1 dst=9 data=0x1234 ready for one cycle, then wen=0 for 4 cycles → fwd_data[1]=0x1234 throughout. ex_hold falls → same value that cycle, fwd_en[1]=0 next cycle.
- Async reset mid-hold: cap_v=1 on operand 0, assert RST between edges → fwd_en[0] drops immediately, counters read 0.
- Saturation (CNT_W=4, FWD_PERF_EN): stall_o held 20 cycles → stall_cycles=15. perf_clr → 0 next edge.
